fp_addsub_seq: RTL and testbench

Parametrised sequential floating-point adder/subtractor, the successor to the bfloat16 adder FSM. It generalises the format through EXP_W/MAN_W, with bfloat16 as the default. It adds a subtract mode, full IEEE-754 round-to-nearest-even with guard/round/sticky, correct subnormal, zero, Inf and NaN handling, exception flags, and a valid/ready handshake on both input and output. It sits between an operand-issue stage and a result consumer in the datapath.

---
 rtl/fp_addsub_seq.sv | 204 ++++++++++++++++++++
 tb/tb_fp_addsub_seq.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_seq.sv
// Sequential IEEE-754 style adder/subtractor, bfloat16 by default.
// One operation in flight: ALIGN -> ADD -> NORM -> ROUND -> DONE.
// Round-to-nearest-even using guard/round/sticky bits below the fraction.
// The result register loads on the first DONE cycle, so out_valid rises five edges after acceptance.
module fp_addsub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clock,
  input  logic         nreset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         flag_nv,
  output logic         flag_of,
  output logic         flag_nx
);
  localparam int SW  = MAN_W + 4;          // {hidden, frac, G, R, S}
  localparam int EW  = EXP_W + 1;          // exponent with headroom for carry and round-up
  localparam int SHW = $clog2(SW + 1);
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;
  state_t r_state, w_next;

  logic [W-1:0]    r_a, r_b, r_rnd_res, r_result;
  logic            r_nan, r_snan, r_a_inf, r_b_inf;
  logic            r_sx, r_eff_sub, r_sign, r_out_valid;
  logic [EW-1:0]   r_ex, r_ne;
  logic [SW-1:0]   r_mx, r_my, r_nm;
  logic [SW:0]     r_sum;
  logic [2:0]      r_rnd_flags, r_flags;

  // operand classification, taken straight from the input ports
  logic w_a_nan, w_b_nan, w_a_snan, w_b_snan, w_a_inf, w_b_inf;
  assign w_a_nan  = (a[W-2:MAN_W] == EMAX) && (a[MAN_W-1:0] != '0);
  assign w_b_nan  = (b[W-2:MAN_W] == EMAX) && (b[MAN_W-1:0] != '0);
  assign w_a_snan = w_a_nan && !a[MAN_W-1];
  assign w_b_snan = w_b_nan && !b[MAN_W-1];
  assign w_a_inf  = (a[W-2:MAN_W] == EMAX) && (a[MAN_W-1:0] == '0);
  assign w_b_inf  = (b[W-2:MAN_W] == EMAX) && (b[MAN_W-1:0] == '0);

  // ALIGN: order by magnitude so the subtract path never goes negative
  logic [W-1:0]     w_x, w_y;
  logic [EXP_W-1:0] w_ex, w_ey, w_diff;
  logic [SW-1:0]    w_mx, w_my, w_my_sh;
  logic [SHW-1:0]   w_sh;
  logic             w_sticky;
  // pick larger operand, build significands and right-shift the smaller one
  always_comb begin
    if (r_a[W-2:0] >= r_b[W-2:0]) begin
      w_x = r_a; w_y = r_b;
    end else begin
      w_x = r_b; w_y = r_a;
    end
    w_ex   = (w_x[W-2:MAN_W] == '0) ? EXP_W'(1) : w_x[W-2:MAN_W];
    w_ey   = (w_y[W-2:MAN_W] == '0) ? EXP_W'(1) : w_y[W-2:MAN_W];
    w_mx   = {|w_x[W-2:MAN_W], w_x[MAN_W-1:0], 3'b000};
    w_my   = {|w_y[W-2:MAN_W], w_y[MAN_W-1:0], 3'b000};
    w_diff = w_ex - w_ey;
    if (32'(w_diff) > 32'(SW - 1)) w_sh = SHW'(SW - 1);
    else                           w_sh = SHW'(w_diff);
    w_my_sh  = w_my >> w_sh;
    w_sticky = |(w_my & ~({SW{1'b1}} << w_sh));
  end

  // ADD
  logic [SW:0] w_sum;
  assign w_sum = r_eff_sub ? ({1'b0, r_mx} - {1'b0, r_my}) : ({1'b0, r_mx} + {1'b0, r_my});

  // NORM: leading-zero count, left shift limited so the exponent stays >= 1
  logic [SHW-1:0] w_lzc, w_nsh;
  logic [EW-1:0]  w_lim;
  // find the highest set bit and clamp the shift at the subnormal boundary
  always_comb begin
    w_lzc = SHW'(SW);
    for (int i = 0; i < SW; i++)
      if (r_sum[i]) w_lzc = SHW'(SW - 1 - i);
    w_lim = r_ex - EW'(1);
    if (32'(w_lzc) > 32'(w_lim)) w_nsh = SHW'(w_lim);
    else                         w_nsh = w_lzc;
  end

  // ROUND: RNE, overflow to Inf, then special-operand overrides
  logic [MAN_W+1:0] w_mant;
  logic [EW-1:0]    w_ef;
  logic [MAN_W-1:0] w_frac;
  logic [W-1:0]     w_res;
  logic             w_inc, w_nv, w_of, w_nx;
  // build the rounded result and exception flags
  always_comb begin
    w_inc  = r_nm[2] & (r_nm[1] | r_nm[0] | r_nm[3]);
    w_mant = {1'b0, r_nm[SW-1:3]} + (MAN_W+2)'(w_inc);
    w_ef   = w_mant[MAN_W+1] ? r_ne + EW'(1) : (w_mant[MAN_W] ? r_ne : '0);
    w_frac = w_mant[MAN_W+1] ? w_mant[MAN_W:1] : w_mant[MAN_W-1:0];
    w_nx   = |r_nm[2:0];
    w_nv   = 1'b0;
    w_of   = 1'b0;
    w_res  = {r_sign, w_ef[EXP_W-1:0], w_frac};
    if (w_ef >= {1'b0, EMAX}) begin
      w_res = {r_sign, EMAX, {MAN_W{1'b0}}};
      w_of  = 1'b1;
      w_nx  = 1'b1;
    end
    if (r_nan) begin
      w_res = QNAN; w_nv = r_snan; w_of = 1'b0; w_nx = 1'b0;
    end else if (r_a_inf && r_b_inf && (r_a[W-1] != r_b[W-1])) begin
      w_res = QNAN; w_nv = 1'b1; w_of = 1'b0; w_nx = 1'b0;
    end else if (r_a_inf) begin
      w_res = r_a; w_of = 1'b0; w_nx = 1'b0;
    end else if (r_b_inf) begin
      w_res = r_b; w_of = 1'b0; w_nx = 1'b0;
    end
  end

  // state register
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // next-state: one step per cycle, DONE waits for the consumer
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_ALIGN;
      S_ALIGN: w_next = S_ADD;
      S_ADD:   w_next = S_NORM;
      S_NORM:  w_next = S_ROUND;
      S_ROUND: w_next = S_DONE;
      S_DONE:  if (r_out_valid && out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign {flag_nv, flag_of, flag_nx} = r_flags;

  // datapath registers, each stage loads only in its own state
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_a <= '0; r_b <= '0; r_nan <= 1'b0; r_snan <= 1'b0; r_a_inf <= 1'b0; r_b_inf <= 1'b0;
      r_sx <= 1'b0; r_eff_sub <= 1'b0; r_ex <= '0; r_mx <= '0; r_my <= '0;
      r_sum <= '0; r_sign <= 1'b0; r_nm <= '0; r_ne <= '0;
      r_rnd_res <= '0; r_rnd_flags <= '0;
      r_out_valid <= 1'b0; r_result <= '0; r_flags <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_a     <= a;
          r_b     <= {b[W-1] ^ sub, b[W-2:0]};
          r_nan   <= w_a_nan | w_b_nan;
          r_snan  <= w_a_snan | w_b_snan;
          r_a_inf <= w_a_inf;
          r_b_inf <= w_b_inf;
        end
        S_ALIGN: begin
          r_sx      <= w_x[W-1];
          r_eff_sub <= w_x[W-1] ^ w_y[W-1];
          r_ex      <= {1'b0, w_ex};
          r_mx      <= w_mx;
          r_my      <= {w_my_sh[SW-1:1], w_my_sh[0] | w_sticky};
        end
        S_ADD: begin
          r_sum  <= w_sum;
          // exact cancellation gives +0; like-signed zeros keep their sign
          r_sign <= (r_eff_sub && w_sum == '0) ? 1'b0 : r_sx;
        end
        S_NORM: begin
          if (r_sum[SW]) begin
            r_nm <= {r_sum[SW:2], r_sum[1] | r_sum[0]};
            r_ne <= r_ex + EW'(1);
          end else begin
            r_nm <= r_sum[SW-1:0] << w_nsh;
            r_ne <= r_ex - EW'(w_nsh);
          end
        end
        S_ROUND: begin
          r_rnd_res   <= w_res;
          r_rnd_flags <= {w_nv, w_of, w_nx};
        end
        S_DONE: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_result    <= r_rnd_res;
            r_flags     <= r_rnd_flags;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Bench for fp_addsub_seq (bfloat16): directed vectors, random ops against an
// exact fixed-point reference, handshake stall, busy-ignore, reset mid-op.
module tb_fp_addsub_seq;
  localparam int W = 16;
  logic clock = 1'b0, nreset = 1'b0, in_valid = 1'b0, sub = 1'b0, out_ready = 1'b1;
  logic [W-1:0] a = '0, b = '0;
  logic in_ready, out_valid, flag_nv, flag_of, flag_nx;
  logic [W-1:0] result;
  int errors = 0, checks = 0;

  always #5 clock = ~clock;

  fp_addsub_seq #(.EXP_W(8), .MAN_W(7)) dut (
    .clock(clock), .nreset(nreset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_nv(flag_nv), .flag_of(flag_of), .flag_nx(flag_nx)
  );

  // value in units of 2^-133 (smallest subnormal), signed
  function automatic logic signed [299:0] to_fix(input logic [15:0] x);
    logic signed [299:0] m;
    int e;
    e = (x[14:7] == 8'h00) ? 1 : int'(x[14:7]);
    m = '0;
    m[7:0] = {|x[14:7], x[6:0]};
    m = m << (e - 1);
    if (x[15]) m = -m;
    return m;
  endfunction

  // reference: exact sum, then round-to-nearest-even into bfloat16; returns {res, nv, of, nx}
  function automatic logic [18:0] ref_op(input logic [15:0] xa, input logic [15:0] xb, input logic s);
    logic [15:0] y;
    logic an, bn, asn, bsn, ai, bi, sg, nx;
    logic signed [299:0] sum;
    logic [299:0] mag, q, rem, half;
    int p, e, sh;
    y   = {xb[15] ^ s, xb[14:0]};
    an  = (xa[14:7] == 8'hFF) && (xa[6:0] != 7'h0);
    bn  = (y[14:7] == 8'hFF) && (y[6:0] != 7'h0);
    asn = an && !xa[6];
    bsn = bn && !y[6];
    ai  = (xa[14:7] == 8'hFF) && (xa[6:0] == 7'h0);
    bi  = (y[14:7] == 8'hFF) && (y[6:0] == 7'h0);
    if (an || bn) return {16'h7FC0, asn | bsn, 2'b00};
    if (ai && bi) return (xa[15] != y[15]) ? {16'h7FC0, 3'b100} : {xa, 3'b000};
    if (ai) return {xa, 3'b000};
    if (bi) return {y, 3'b000};
    sum = to_fix(xa) + to_fix(y);
    if (sum == '0) return {xa[15] & y[15], 15'h0, 3'b000};
    sg  = sum[299];
    mag = sg ? 300'(-sum) : 300'(sum);
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    if (p < 7) return {sg, 8'h00, mag[6:0], 3'b000};
    e  = p - 6;
    sh = e - 1;
    q  = mag >> sh;
    rem = mag - (q << sh);
    nx = (rem != '0);
    if (sh > 0) begin
      half = 300'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 300'(1);
    end
    if (q == 300'(256)) begin q = 300'(128); e++; end
    if (e >= 255) return {sg, 8'hFF, 7'h0, 3'b011};
    return {sg, 8'(e), q[6:0], 2'b00, nx};
  endfunction

  // operand generator biased toward close exponents and special classes
  function automatic logic [15:0] rnd_op(input logic [15:0] near);
    logic [15:0] v;
    int k, e;
    v = 16'($urandom);
    k = int'($urandom_range(0, 15));
    case (k)
      0: v[14:7] = 8'h00;
      1: v[14:0] = 15'h0;
      2: v[14:0] = 15'h7F80;
      3: begin v[14:7] = 8'hFF; v[6:0] = 7'($urandom_range(1, 127)); end
      4, 5, 6, 7, 8, 9: begin
        e = int'(near[14:7]) + int'($urandom_range(0, 6)) - 3;
        if (e < 0) e = 0;
        if (e > 254) e = 254;
        v[14:7] = 8'(e);
      end
      10: begin v[14:0] = near[14:0]; v[0] = ~v[0]; end
      11: v[14:7] = 8'hFE;
      default: ;
    endcase
    return v;
  endfunction

  // issue one op with out_ready high; returns result, flags and edges to out_valid
  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic isub,
                        output logic [15:0] r, output logic [2:0] f, output int lat);
    out_ready = 1'b1;
    @(negedge clock);
    a = ia; b = ib; sub = isub; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    r = result;
    f = {flag_nv, flag_of, flag_nx};
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 16'h0 || {flag_nv, flag_of, flag_nx} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b res=%h flags=%b, want 0/0000/000", out_valid, result, {flag_nv, flag_of, flag_nx});
    end
    repeat (3) @(posedge clock);
    @(negedge clock) nreset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  localparam logic [51:0] VECS [0:12] = '{
    {16'h3F80, 16'h3F80, 1'b0, 16'h4000, 3'b000},
    {16'h3F80, 16'h3F80, 1'b1, 16'h0000, 3'b000},
    {16'h8000, 16'h8000, 1'b0, 16'h8000, 3'b000},
    {16'h3F80, 16'h3B80, 1'b0, 16'h3F80, 3'b001},
    {16'h3F81, 16'h3B80, 1'b0, 16'h3F82, 3'b001},
    {16'h7F7F, 16'h7F7F, 1'b0, 16'h7F80, 3'b011},
    {16'h0001, 16'h0001, 1'b0, 16'h0002, 3'b000},
    {16'h0080, 16'h0001, 1'b1, 16'h007F, 3'b000},
    {16'h7F80, 16'hFF80, 1'b0, 16'h7FC0, 3'b100},
    {16'h7F81, 16'h3F80, 1'b0, 16'h7FC0, 3'b100},
    {16'h7F80, 16'h3F80, 1'b0, 16'h7F80, 3'b000},
    {16'h7FC0, 16'h3F80, 1'b0, 16'h7FC0, 3'b000},
    {16'h7F80, 16'h7F80, 1'b1, 16'h7FC0, 3'b100}
  };

  task automatic test_directed();
    logic [51:0] v;
    logic [15:0] r;
    logic [2:0] f;
    int lat;
    for (int i = 0; i < 13; i++) begin
      v = VECS[i];
      run_op(v[51:36], v[35:20], v[19], r, f, lat);
      checks++;
      if (r !== v[18:3] || f !== v[2:0]) begin
        errors++;
        $display("FAIL directed_%0d: %h %s %h got %h flags %b, want %h flags %b",
                 i, v[51:36], v[19] ? "-" : "+", v[35:20], r, f, v[18:3], v[2:0]);
      end
      checks++;
      if (lat !== 5) begin
        errors++;
        $display("FAIL directed_latency_%0d: got %0d edges want 5", i, lat);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] xa, xb, r;
    logic [2:0] f;
    logic s;
    logic [18:0] exp_v;
    int lat;
    for (int i = 0; i < 400; i++) begin
      xa = rnd_op(16'($urandom));
      xb = rnd_op(xa);
      s  = 1'($urandom);
      exp_v = ref_op(xa, xb, s);
      run_op(xa, xb, s, r, f, lat);
      checks++;
      if ({r, f} !== exp_v || lat !== 5) begin
        errors++;
        $display("FAIL random_%0d: %h %s %h got %h flags %b lat %0d, want %h flags %b lat 5",
                 i, xa, s ? "-" : "+", xb, r, f, lat, exp_v[18:3], exp_v[2:0]);
      end
    end
  endtask

  task automatic test_stall();
    int n;
    out_ready = 1'b0;
    @(negedge clock);
    a = 16'h3F80; b = 16'h4000; sub = 1'b0; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || result !== 16'h4040) begin
      errors++;
      $display("FAIL stall_result: got valid=%b res=%h, want 1/4040", out_valid, result);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      checks++;
      if (out_valid !== 1'b1 || result !== 16'h4040 || in_ready !== 1'b0 ||
          {flag_nv, flag_of, flag_nx} !== 3'b000) begin
        errors++;
        $display("FAIL stall_hold_%0d: got valid=%b res=%h in_ready=%b, want 1/4040/0", i, out_valid, result, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: got valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_busy_ignore();
    int n;
    logic seen;
    out_ready = 1'b1;
    @(negedge clock);
    a = 16'h3F80; b = 16'h3F80; sub = 1'b0; in_valid = 1'b1;
    @(posedge clock); #1;
    a = 16'h4000; b = 16'h4000; sub = 1'b1;
    repeat (3) @(posedge clock);
    #1 in_valid = 1'b0;
    n = 3;
    while (!out_valid && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    checks++;
    if (result !== 16'h4000 || n !== 5) begin
      errors++;
      $display("FAIL busy_result: got %h after %0d edges, want 4000 after 5", result, n);
    end
    @(posedge clock); #1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL busy_second_op: got out_valid=1 for ignored request, want 0");
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    logic [15:0] r;
    logic [2:0] f;
    int lat;
    @(negedge clock);
    a = 16'h3F80; b = 16'h3F80; sub = 1'b0; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #2;
    nreset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_state: got valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
    end
    @(negedge clock) nreset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_no_output: got out_valid=1, want 0");
    end
    run_op(16'h4000, 16'h3F80, 1'b1, r, f, lat);
    checks++;
    if (r !== 16'h3F80 || f !== 3'b000 || lat !== 5) begin
      errors++;
      $display("FAIL reset_mid_next_op: got %h flags %b lat %0d, want 3f80 000 5", r, f, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] r;
    logic [2:0] f;
    int lat;
    run_op(16'h4040, 16'h3F80, 1'b0, r, f, lat);
    checks++;
    if (r !== 16'h4080 || f !== 3'b000 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: got %h flags %b in_ready %b, want 4080 000 1", r, f, in_ready);
    end
    run_op(16'h4080, 16'hC000, 1'b0, r, f, lat);
    checks++;
    if (r !== 16'h4000 || f !== 3'b000 || lat !== 5) begin
      errors++;
      $display("FAIL b2b_second: got %h flags %b lat %0d, want 4000 000 5", r, f, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_stall();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
